// File: rtl/ser_pkg.sv
// Shared definitions for the serial load controller slice.
//   ST_IDLE / ST_SHIFT : FSM state encodings for ser_load_ctrl
//   clog2()            : ceiling log2 used to size pointers, counters and level ports
package ser_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Smallest r with 2**r >= value; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ser_word_fifo.sv
// Synchronous word FIFO on serclk with asynchronous active-low reset.
//   serclk, reset_n : clock, async active-low reset
//   push, din       : write a word (ignored while full)
//   pop             : drop the head word (ignored while empty)
//   dout            : current head word, combinational read
//   full, empty     : status from the current level
//   level           : words currently stored
module ser_word_fifo
  import ser_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          serclk,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WORD_WIDTH-1:0]         din,
  output logic [WORD_WIDTH-1:0]         dout,
  output logic                          full,
  output logic                          empty,
  output logic [clog2(FIFO_DEPTH):0]    level
);

  localparam int unsigned AddrWidth = clog2(FIFO_DEPTH);

  logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AddrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AddrWidth:0]    count_q;
  logic                  do_push, do_pop;

  assign full    = (count_q == (AddrWidth + 1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = count_q;

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge serclk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge serclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrWidth'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrWidth'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AddrWidth + 1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AddrWidth + 1)'(1);
    end
  end

endmodule

// File: rtl/ser_load_ctrl.sv
// Feeder for a parallel-to-serial shifter. Buffers producer words in a FIFO and
// issues a registered parallel word with a one-cycle active-low load strobe every
// WORD_WIDTH + IDLE_BITS cycles while words are available.
//   serclk, reset_n       : clock, async active-low reset
//   wr_data, wr_valid     : producer word and valid
//   wr_ready              : FIFO not full (from current level only)
//   par_data_out          : word for the shifter parallel input
//   par_load_out_n        : active-low load strobe, one cycle wide
//   busy                  : a word period is in progress
//   word_done             : one-cycle pulse at the end of each word period
//   fifo_level            : words currently buffered
module ser_load_ctrl
  import ser_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IDLE_BITS  = 0
) (
  input  logic                          serclk,
  input  logic                          reset_n,
  input  logic [WORD_WIDTH-1:0]         wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [WORD_WIDTH-1:0]         par_data_out,
  output logic                          par_load_out_n,
  output logic                          busy,
  output logic                          word_done,
  output logic [clog2(FIFO_DEPTH):0]    fifo_level
);

  localparam int unsigned Period   = WORD_WIDTH + IDLE_BITS;
  localparam int unsigned CntWidth = clog2(Period + 1);

  logic [0:0]            state_q, state_d;
  logic [CntWidth-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0] par_data_q, par_data_d;
  logic                  load_n_q, load_n_d;
  logic                  word_done_q, word_done_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WORD_WIDTH-1:0] fifo_head;

  assign wr_ready  = ~fifo_full;
  assign fifo_push = wr_valid & wr_ready;

  ser_word_fifo #(
    .WORD_WIDTH (WORD_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .serclk  (serclk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (wr_data),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    par_data_d  = par_data_q;
    load_n_d    = 1'b1;
    word_done_d = 1'b0;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          par_data_d = fifo_head;
          load_n_d   = 1'b0;
          fifo_pop   = 1'b1;
          bit_cnt_d  = CntWidth'(1);
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == CntWidth'(Period)) begin
          word_done_d = 1'b1;
          // Reloading on the final count keeps strobes exactly Period apart.
          if (!fifo_empty) begin
            par_data_d = fifo_head;
            load_n_d   = 1'b0;
            fifo_pop   = 1'b1;
            bit_cnt_d  = CntWidth'(1);
          end else begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CntWidth'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge serclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      par_data_q  <= '0;
      load_n_q    <= 1'b1;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      par_data_q  <= par_data_d;
      load_n_q    <= load_n_d;
      word_done_q <= word_done_d;
    end
  end

  assign par_data_out   = par_data_q;
  assign par_load_out_n = load_n_q;
  assign word_done      = word_done_q;
  assign busy           = (state_q == ST_SHIFT);

endmodule
